// File: rtl/serial_tx_4_if.sv
// serial_tx_4_if -- handshake and serial-line bundle for serial_tx_4.
//
// Signals:
//   i_d      [3:0]  parallel word offered by the source
//   i_valid         source asserts that i_d holds a word to send
//   o_ready         transmitter idle; the word is taken when i_valid & o_ready
//   o_tx            serial line, idles high
//   o_busy          frame in progress (inverse of o_ready)
//
// Modports:
//   master  the word source / line observer (drives i_d, i_valid)
//   slave   the transmitter (drives o_ready, o_tx, o_busy)
interface serial_tx_4_if;
  logic [3:0] i_d;
  logic       i_valid;
  logic       o_ready;
  logic       o_tx;
  logic       o_busy;

  modport master (
    output i_d,
    output i_valid,
    input  o_ready,
    input  o_tx,
    input  o_busy
  );

  modport slave (
    input  i_d,
    input  i_valid,
    output o_ready,
    output o_tx,
    output o_busy
  );
endinterface

// File: rtl/serial_tx_4.sv
// serial_tx_4 -- 4-bit parallel-to-serial transmitter.
//
// Frame: one start bit (0), four data bits LSB first, optional even-parity
// bit, one stop bit (1). Every bit is held for CLKS_PER_BIT cycles.
//
// Ports:
//   i_clk     clock, all state changes on the rising edge
//   i_reset   synchronous active-high reset
//   bus       serial_tx_4_if.slave (i_d, i_valid, o_ready, o_tx, o_busy)
//
// Parameters:
//   CLKS_PER_BIT  cycles per serial bit, 1..255 (default 2)
//
// Configuration macro:
//   SERIAL_TX_PARITY_EN  when defined, a PARITY state carrying the XOR of
//                        the four captured bits sits between DATA and STOP.
module serial_tx_4 #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  serial_tx_4_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  clk_cnt_q, clk_cnt_d;
  logic [1:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        bit_done;

  // The outputs are registered from the next-state values, so the line level
  // a state produces appears in the same cycle the state register holds it;
  // this puts the first start-bit cycle directly after the accept edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= 8'd0;
      bit_cnt_q <= 2'd0;
      shift_q   <= 4'd0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and next-output logic. Each non-idle state holds its line
  // level until the per-bit counter reaches its last count, then loads the
  // level of the following bit. The bit counter indexes the captured word
  // directly, so the word is never shifted.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    bit_done  = (clk_cnt_q == LAST_CNT);

    case (state_q)
      IDLE: begin
        clk_cnt_d = 8'd0;
        bit_cnt_d = 2'd0;
        tx_d      = 1'b1;
        if (bus.i_valid) begin
          shift_d = bus.i_d;
          state_d = START;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (bit_done) begin
          clk_cnt_d = 8'd0;
          bit_cnt_d = 2'd0;
          state_d   = DATA;
          tx_d      = shift_q[0];
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end

      DATA: begin
        if (bit_done) begin
          clk_cnt_d = 8'd0;
          if (bit_cnt_q == 2'd3) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^shift_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 2'd1;
            tx_d      = shift_q[bit_cnt_d];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end

`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          clk_cnt_d = 8'd0;
          state_d   = STOP;
          tx_d      = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end
`endif

      STOP: begin
        if (bit_done) begin
          clk_cnt_d = 8'd0;
          state_d   = IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
        tx_d = 1'b1;
      end

      default: begin
        state_d   = IDLE;
        clk_cnt_d = 8'd0;
        bit_cnt_d = 2'd0;
        tx_d      = 1'b1;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = !ready_d;
  end

  assign bus.o_tx    = tx_q;
  assign bus.o_ready = ready_q;
  assign bus.o_busy  = busy_q;

endmodule

// File: tb/tb_serial_tx_4.sv
// tb_serial_tx_4 -- randomized scoreboard bench for serial_tx_4.
//
// The main instance (CLKS_PER_BIT=2) is driven by a stimulus process that
// pushes the expected line waveform of every accepted word onto a queue; an
// independent negedge monitor pops a waveform at each accept edge it predicts
// and compares o_tx / o_ready / o_busy cycle by cycle. A second instance
// (CLKS_PER_BIT=1) gets a short directed check.
// Honours SERIAL_TX_PARITY_EN the same way the design does.
module tb_serial_tx_4;

`ifdef SERIAL_TX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif
  localparam int CPB   = 2;
  localparam int LIMIT = 100;

  typedef struct {
    logic [31:0] bits;
    int          len;
  } frame_t;

  logic clk;
  logic rst;
  logic rst1;
  int   total;
  int   bad;

  serial_tx_4_if bus ();
  serial_tx_4_if bus1 ();

  serial_tx_4 #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  serial_tx_4 #(.CLKS_PER_BIT(1)) dut1 (
    .i_clk   (clk),
    .i_reset (rst1),
    .bus     (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  frame_t sb[$];

  // Reference: the frame is a list of symbols (start, d0..d3, parity, stop),
  // each repeated cpb times on the line.
  function automatic frame_t build_frame(input logic [3:0] w, input int cpb);
    frame_t f;
    int     nsym;
    logic   s;
    f.bits = '0;
    f.len  = 0;
    nsym   = PARITY_ON ? 7 : 6;
    for (int k = 0; k < nsym; k++) begin
      if (k == 0)             s = 1'b0;
      else if (k <= 4)        s = w[k-1];
      else if (k == nsym - 1) s = 1'b1;
      else                    s = w[0] ^ w[1] ^ w[2] ^ w[3];
      for (int c = 0; c < cpb; c++) begin
        f.bits[f.len] = s;
        f.len++;
      end
    end
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor state
  logic [31:0] cur_bits;
  int          cur_len;
  int          cur_pos;
  bit          armed;
  logic        exp_ready;
  logic        exp_tx;
  logic        rst_s;
  logic        vld_s;

  initial begin
    cur_bits  = '0;
    cur_len   = 0;
    cur_pos   = 0;
    armed     = 1'b0;
    exp_ready = 1'b1;
    exp_tx    = 1'b1;
    rst_s     = 1'b0;
    vld_s     = 1'b0;
  end

  // At each negedge, decide what the previous rising edge did (reset, accept
  // or nothing) from the inputs recorded one negedge earlier, then compare.
  always @(negedge clk) begin
    frame_t f;
    if (rst_s) begin
      cur_len = 0;
      cur_pos = 0;
      armed   = 1'b1;
    end else if (armed && cur_pos >= cur_len && exp_ready && vld_s) begin
      checkOutput("sb_has_frame", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        f        = sb.pop_front();
        cur_bits = f.bits;
        cur_len  = f.len;
        cur_pos  = 0;
      end
    end
    if (armed) begin
      if (cur_pos < cur_len) begin
        exp_tx    = cur_bits[cur_pos];
        exp_ready = 1'b0;
        cur_pos++;
      end else begin
        exp_tx    = 1'b1;
        exp_ready = 1'b1;
      end
      checkOutput("tx", 32'(bus.o_tx), 32'(exp_tx));
      checkOutput("ready", 32'(bus.o_ready), 32'(exp_ready));
      checkOutput("busy", 32'(bus.o_busy), 32'(!exp_ready));
    end
    rst_s = rst;
    vld_s = bus.i_valid;
  end

  // Offer w until it is taken, push its expected waveform, then drive
  // 'after' onto i_d. With keep=1 i_valid stays high for the next word.
  task automatic applyStimulus(input logic [3:0] w, input bit keep,
                               input logic [3:0] after);
    int   waited;
    logic rdy;
    waited = 0;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b1;
    bus.i_d     = w;
    do begin
      @(negedge clk);
      rdy = bus.o_ready;
      @(posedge clk);
      waited++;
    end while (rdy !== 1'b1 && waited < LIMIT);
    if (rdy !== 1'b1) begin
      checkOutput("accept_timeout", 32'(rdy), 32'd1);
    end else begin
      sb.push_back(build_frame(w, CPB));
    end
    #1;
    if (!keep) bus.i_valid = 1'b0;
    bus.i_d = after;
  endtask

  task automatic run_cpb1(input logic [3:0] w);
    frame_t f;
    f = build_frame(w, 1);
    @(negedge clk);
    checkOutput("cpb1_idle_ready", 32'(bus1.o_ready), 32'd1);
    checkOutput("cpb1_idle_tx", 32'(bus1.o_tx), 32'd1);
    @(posedge clk);
    #1;
    bus1.i_valid = 1'b1;
    bus1.i_d     = w;
    @(posedge clk);
    #1;
    bus1.i_valid = 1'b0;
    bus1.i_d     = ~w;
    for (int i = 0; i < f.len; i++) begin
      @(negedge clk);
      checkOutput("cpb1_tx", 32'(bus1.o_tx), 32'(f.bits[i]));
      checkOutput("cpb1_busy", 32'(bus1.o_busy), 32'd1);
    end
    @(negedge clk);
    checkOutput("cpb1_ready_after", 32'(bus1.o_ready), 32'd1);
  endtask

  initial begin
    int waited;
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    rst1         = 1'b1;
    bus.i_valid  = 1'b0;
    bus.i_d      = 4'd0;
    bus1.i_valid = 1'b0;
    bus1.i_d     = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst  = 1'b0;
    rst1 = 1'b0;

    // Directed single word, then a word whose i_d changes after acceptance.
    applyStimulus(4'b1011, 1'b0, 4'b0000);
    repeat (2) @(posedge clk);
    applyStimulus(4'b0110, 1'b0, 4'b1001);
    repeat (1) @(posedge clk);

    // i_valid held high: frames separated by exactly one idle cycle.
    applyStimulus(4'b1111, 1'b1, 4'b1111);
    applyStimulus(4'b1111, 1'b1, 4'b1111);
    applyStimulus(4'b1111, 1'b0, 4'b1111);

    // Reset during the second data bit aborts the frame.
    applyStimulus(4'b1101, 1'b0, 4'b0000);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(4'b0001, 1'b0, 4'b0000);

    // Reset and a valid word on the same edge: the word is dropped.
    waited = 0;
    while ((sb.size() != 0 || cur_pos < cur_len) && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b1;
    bus.i_d     = 4'b0101;
    rst         = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    rst         = 1'b0;
    repeat (3) @(posedge clk);

    // Random words with random gaps and i_d scribbled after acceptance.
    for (int n = 0; n < 20; n++) begin
      applyStimulus(4'($urandom), 1'b0, 4'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    waited = 0;
    while ((sb.size() != 0 || cur_pos < cur_len) && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    checkOutput("drained", 32'(sb.size() == 0 && cur_pos >= cur_len), 32'd1);

    run_cpb1(4'b0000);
    run_cpb1(4'b1010);
    run_cpb1(4'($urandom));

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
